// File: rtl/seg_scan_if.sv
// seg_scan_if: bus between the value source (counter/datapath) and the
// 7-segment scan controller.
//   enable     : scan enable; low forces the display dark
//   value      : packed nibbles, digit 0 = value[3:0] = rightmost digit
//   load       : one-cycle strobe capturing value
//   hex        : nibble for the shared hex-to-segment decoder
//   anode_n    : active-low digit enables
//   frame_done : one-cycle pulse at the end of each full frame
// Handshake: load is a plain strobe with no back-pressure; every cycle it is
// high, value is taken. Outputs are registered and always valid.
interface seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   value;
  logic                  load;
  logic [3:0]            hex;
  logic [DIGITS-1:0]     anode_n;
  logic                  frame_done;

  modport master (
    output enable, value, load,
    input  hex, anode_n, frame_done
  );

  modport slave (
    input  enable, value, load,
    output hex, anode_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display sharing one hex decoder.
// Each slot: BLANK_CYCLES with all anodes off, then CLK_DIV cycles with one
// digit lit. value is double-buffered (pending -> shadow at frame boundary)
// so a frame is never torn.
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   bus         : seg_scan_if slave modport (enable/value/load in,
//                 hex/anode_n/frame_done out, all outputs registered)
//   dbg_state_o : current FSM state (0=IDLE, 1=BLANK, 2=SHOW)
// Optional feature macro: SEG_SCAN_LZ_BLANK_EN -- leading-zero suppression;
// digits idx>0 stay dark when shadow nibbles idx..DIGITS-1 are all zero.
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  seg_scan_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(DIGITS);
  localparam int VW   = 4 * DIGITS;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic [VW-1:0]     pending_q, pending_d;
  logic              pend_valid_q, pend_valid_d;
  logic [3:0]        hex_q, hex_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic              fd_q, fd_d;
  logic              frame_end;
  logic              lz_dark;

  // State, counters, buffers and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      hex_q        <= 4'h0;
      anode_q      <= '1;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      hex_q        <= hex_d;
      anode_q      <= anode_d;
      fd_q         <= fd_d;
    end
  end

  // Next-state, slot sequencing and value double-buffering.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_end    = 1'b0;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;

    if (!bus.enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Shadow only changes while idle or at the frame boundary; a load that
    // coincides with the boundary bypasses pending and wins outright.
    if (bus.load) begin
      pending_d = bus.value;
      if (state_q == S_IDLE || frame_end) begin
        shadow_d     = bus.value;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
      end
    end else if (frame_end && pend_valid_q) begin
      shadow_d     = pending_q;
      pend_valid_d = 1'b0;
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Dark when this digit and every more-significant digit are zero.
  assign lz_dark = (idx_q != '0) && ((shadow_q >> (4 * idx_q)) == '0);
`else
  assign lz_dark = 1'b0;
`endif

  // Output decode from current state; enable low forces dark immediately.
  always_comb begin
    hex_d   = hex_q;
    anode_d = '1;
    fd_d    = frame_end;
    if (bus.enable) begin
      case (state_q)
        S_BLANK: hex_d = shadow_q[4*idx_q +: 4];
        S_SHOW:  if (!lz_dark) anode_d[idx_q] = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.hex        = hex_q;
  assign bus.anode_n    = anode_q;
  assign bus.frame_done = fd_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2.
// A slot is 6 cycles (2 dark, 4 lit); a frame is 24 cycles.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .DIGITS(4),
    .CLK_DIV(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Which digits light up for a given shadow value.
  function automatic logic [3:0] lit_mask(input logic [15:0] v);
    logic [3:0] m;
`ifdef SEG_SCAN_LZ_BLANK_EN
    m = 4'b0001;
    for (int i = 1; i < 4; i++)
      if ((v >> (4 * i)) != 16'h0) m[i] = 1'b1;
`else
    m = 4'hF;
`endif
    return m;
  endfunction

  // Starts right after the edge on which the FSM entered BLANK for digit 0.
  // Optional loads are driven at frame ticks la and lb (-1 = none).
  task automatic run_frame(input logic [15:0] v, input int n_ticks,
                           input int la, input logic [15:0] lva,
                           input int lb, input logic [15:0] lvb);
    logic [3:0] m;
    logic [3:0] cur;
    logic [3:0] exp_an;
    int         i;
    int         k;
    m   = lit_mask(v);
    cur = 4'h0;
    exp_q.delete();
    for (int d = 0; d < 4; d++) exp_q.push_back(v[4*d +: 4]);
    for (int t = 0; t < n_ticks; t++) begin
      i = t / 6;
      k = t % 6 + 1;
      if (t == la) begin
        bus.load  = 1'b1;
        bus.value = lva;
      end else if (t == lb) begin
        bus.load  = 1'b1;
        bus.value = lvb;
      end else begin
        bus.load = 1'b0;
      end
      if (k == 1) cur = exp_q.pop_front();
      tick();
      exp_an = 4'hF;
      if (k >= 3 && m[i]) exp_an[i] = 1'b0;
      check($sformatf("anode t%0d", t), 32'(bus.anode_n), 32'(exp_an));
      check($sformatf("hex t%0d", t), 32'(bus.hex), 32'(cur));
      check($sformatf("frame_done t%0d", t), 32'(bus.frame_done),
            32'((i == 3 && k == 6) ? 1 : 0));
    end
    bus.load = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.load   = 1'b0;
    bus.value  = 16'h0;

    // Reset held 3 cycles with enable high.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst anode", 32'(bus.anode_n), 32'hF);
      check("rst hex", 32'(bus.hex), 32'h0);
      check("rst frame_done", 32'(bus.frame_done), 32'h0);
      check("rst state", 32'(dbg_state), 32'h0);
    end
    reset = 1'b0;
    tick();  // IDLE -> BLANK
    check("first blank anode", 32'(bus.anode_n), 32'hF);
    run_frame(16'h0000, 24, -1, 16'h0, -1, 16'h0);

    // Go idle, load 1234 directly into shadow, restart.
    bus.enable = 1'b0;
    tick();
    check("idle anode", 32'(bus.anode_n), 32'hF);
    check("idle state", 32'(dbg_state), 32'h0);
    bus.load  = 1'b1;
    bus.value = 16'h1234;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("restart anode", 32'(bus.anode_n), 32'hF);
    run_frame(16'h1234, 24, -1, 16'h0, -1, 16'h0);
    // Mid-frame load while digit 1 is lit.
    run_frame(16'h1234, 24, 9, 16'hABCD, -1, 16'h0);
    // Two loads in one frame; last one wins.
    run_frame(16'hABCD, 24, 3, 16'h1111, 15, 16'h2222);
    // Load on the commit cycle overrides an older pending value.
    run_frame(16'h2222, 24, 5, 16'h9999, 23, 16'h5678);
    // Pending load, then drop enable while digit 2 is lit.
    run_frame(16'h5678, 15, 3, 16'h4321, -1, 16'h0);
    bus.enable = 1'b0;
    tick();
    check("drop anode", 32'(bus.anode_n), 32'hF);
    check("drop frame_done", 32'(bus.frame_done), 32'h0);
    check("drop state", 32'(dbg_state), 32'h0);
    for (int c = 0; c < 30; c++) begin
      tick();
      check("off anode", 32'(bus.anode_n), 32'hF);
      check("off frame_done", 32'(bus.frame_done), 32'h0);
    end
    bus.enable = 1'b1;
    tick();
    check("reenable anode", 32'(bus.anode_n), 32'hF);
    run_frame(16'h5678, 24, -1, 16'h0, -1, 16'h0);
    run_frame(16'h4321, 24, -1, 16'h0, -1, 16'h0);

    // Leading-zero patterns (all digits lit unless the feature is built in).
    bus.enable = 1'b0;
    tick();
    bus.load  = 1'b1;
    bus.value = 16'h0040;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("lz restart anode", 32'(bus.anode_n), 32'hF);
    run_frame(16'h0040, 24, 0, 16'h0000, -1, 16'h0);
    run_frame(16'h0000, 24, -1, 16'h0, -1, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Shares a single hex-to-segment decoder among DIGITS digits: presents one nibble per slot on `hex` and enables the matching anode.
- Sits between the counter/datapath, which supplies a packed `value`, and the decoder plus board anode pins.
- Inserts a blanking gap between slots to prevent ghosting.
- Double-buffers `value` so a frame is never torn.

Parameters:
- DIGITS, 4: number of display digits; 2..8.
- CLK_DIV, 1000: clk cycles each digit is lit per slot; ≥1.
- BLANK_CYCLES, 16: clk cycles all anodes are off before each slot; ≥1.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- enable  in  1: scan enable; low forces display dark.
- value  in  4*DIGITS: packed nibbles; digit 0 = value[3:0] = rightmost digit.
- load  in  1: one-cycle strobe; captures `value`.
- hex  out  4: nibble for the shared decoder; registered.
- anode_n  out  DIGITS: active-low digit enables; registered.
- frame_done  out  1: one-cycle pulse at the end of each full frame.

Behaviour:
- Reset values:
  - Internal: state=IDLE, idx=0, slot counter=0, shadow=0, pending=0, pend_valid=0.
  - Outputs: hex=0, anode_n=all 1s, frame_done=0.
  - Reset overrides every other input in the same cycle.
- States: IDLE, BLANK, SHOW. All outputs are registered; output changes appear the cycle after the state/counter change that causes them.
- IDLE:
  - anode_n all 1s.
  - enable=1 → BLANK with idx=0 and counter=0.
- BLANK:
  - anode_n all 1s; hex = shadow[4*idx+:4].
  - Counts BLANK_CYCLES cycles, then → SHOW with counter cleared.
- SHOW:
  - anode_n[idx]=0, all other bits 1; hex unchanged.
  - Lasts CLK_DIV cycles. At the last cycle:
    - If idx==DIGITS-1: pulse frame_done for 1 cycle, set idx=0, commit pending to shadow if pend_valid.
    - Otherwise idx=idx+1.
    - Then → BLANK.
- Slot period is BLANK_CYCLES+CLK_DIV; frame period is DIGITS*(BLANK_CYCLES+CLK_DIV) cycles.
- enable=0 in any state → IDLE on the next edge, anodes dark, idx=0.
  - frame_done is not pulsed.
  - pending is preserved.
- load=1:
  - value → pending and pend_valid=1.
  - In IDLE, shadow is also loaded directly and pend_valid is cleared.
  - A second load before the frame boundary overwrites pending; last one wins.
  - load on the same cycle as the frame-boundary commit: the new `value` goes straight to shadow, pend_valid=0.
- Shadow never changes mid-frame, so all digits of one frame come from one snapshot.
- idx wraps DIGITS-1 → 0, never beyond.
- Counters are sized $clog2(max(CLK_DIV,BLANK_CYCLES)+1).

Optional Feature:
SEG_SCAN_LZ_BLANK_EN (leading-zero suppression).
- Defined: during SHOW of digit idx>0, anode_n stays all 1s if shadow nibbles idx..DIGITS-1 are all zero. Digit 0 is always lit, so value 0 shows "0".
  - Slot timing and frame_done timing are unchanged.
  - Evaluated on shadow only.
- Undefined: every digit is lit in its slot.

Test Plan:
All scenarios use DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2.
- Reset held 3 cycles with enable=1 → anode_n=4'b1111, hex=0, frame_done=0 throughout; after release, first anode_n=4'b1110 appears 2 cycles after BLANK entry and holds 4 cycles.
- load with value=16'h1234 in IDLE, then enable=1 → hex sequence 4,3,2,1; anode_n 1110,1101,1011,0111, each lit 4 cycles with 2 dark cycles before it; frame_done pulses once every 24 cycles.
- Mid-frame load with 16'hABCD while digit 1 is shown → rest of the frame still shows 2,1; next frame shows D,C,B,A.
- Two loads in one frame (16'h1111 then 16'h2222) → next frame shows 2,2,2,2; 16'h1111 is never displayed.
- enable dropped during SHOW of digit 2 → anode_n=4'b1111 next cycle, no frame_done; re-enable → restarts at digit 0 after 2 blank cycles.
- With SEG_SCAN_LZ_BLANK_EN defined and value=16'h0040 → digits 3,2 stay dark in their slots, digit 1 shows 4, digit 0 shows 0; with value=16'h0000 only digit 0 lights.
